// File: rtl/dmem_arbiter_if.sv
// Data-memory arbitration bundle: two requester ports, their read responses,
// the global lock enable and the single-port memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  lock;

    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requesters plus the memory itself sit on the master side.
    modport master (
        output lock,
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  lock,
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: fixed priority to port 0,
// starvation counter forcing a port-1 grant, one-cycle read response routing.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      starve_cnt;
    logic                  force1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    logic                  rsp_vld_p1;
    logic                  rsp_owner_p1;

    // Grant: port 1 only wins when port 0 is idle or it has been starved long enough.
    always_comb begin
        force1 = (starve_cnt == CNT_MAX);
        gnt1   = !reset && bus.lock && bus.req1_valid && (force1 || !bus.req0_valid);
        gnt0   = !reset && bus.lock && bus.req0_valid && !gnt1;
    end

    always_comb begin
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (gnt1) begin
            mem_we_c    = bus.req1_we;
            mem_addr_c  = bus.req1_addr;
            mem_wdata_c = bus.req1_wdata;
        end else if (gnt0) begin
            mem_we_c    = bus.req0_we;
            mem_addr_c  = bus.req0_addr;
            mem_wdata_c = bus.req0_wdata;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.mem_en     = gnt0 || gnt1;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;

    // Counts cycles port 1 waited behind port 0; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (bus.lock) begin
            if (gnt1 || !bus.req1_valid) begin
                starve_cnt <= '0;
            end else if (gnt0 && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Stage p0 -> p1: the response stage runs regardless of lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_vld_p1   <= 1'b0;
            rsp_owner_p1 <= 1'b0;
        end else begin
            rsp_vld_p1   <= (gnt0 || gnt1) && !mem_we_c;
            rsp_owner_p1 <= gnt1;
        end
    end

    assign bus.rsp0_valid = rsp_vld_p1 && !rsp_owner_p1;
    assign bus.rsp1_valid = rsp_vld_p1 &&  rsp_owner_p1;
    assign bus.rsp0_rdata = bus.rsp0_valid ? bus.mem_rdata : '0;
    assign bus.rsp1_rdata = bus.rsp1_valid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a write-first registered RAM model.
module tb_dmem_arbiter;
    logic clk;
    logic reset;

    dmem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered, write-first memory; preloaded while reset is held across a clock edge.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h01] <= 16'h00A1;
            mem[8'h02] <= 16'h00A2;
            mem[8'h03] <= 16'h00A3;
            mem[8'h10] <= 16'h1234;
            bus.mem_rdata <= 16'h0000;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
                bus.mem_rdata <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            end
        end
    end

    typedef struct {
        logic        lk;
        logic        v0, we0;
        logic [15:0] a0, d0;
        logic        v1, we1;
        logic [15:0] a1, d1;
        logic [69:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected layout: {rdy0, rdy1, en, we, addr, wdata, rsp0_v, rsp0_d, rsp1_v, rsp1_d}
    function automatic void add(
        input logic lk,
        input logic v0, input logic we0, input logic [15:0] a0, input logic [15:0] d0,
        input logic v1, input logic we1, input logic [15:0] a1, input logic [15:0] d1,
        input logic r0, input logic r1, input logic en, input logic we,
        input logic [15:0] addr, input logic [15:0] wd,
        input logic s0v, input logic [15:0] s0d, input logic s1v, input logic [15:0] s1d);
        vec_t v;
        v.lk = lk; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.exp = {r0, r1, en, we, addr, wd, s0v, s0d, s1v, s1d};
        vecs.push_back(v);
    endfunction

    function automatic logic [69:0] sample();
        return {bus.req0_ready, bus.req1_ready, bus.mem_en, bus.mem_we, bus.mem_addr,
                bus.mem_wdata, bus.rsp0_valid, bus.rsp0_rdata, bus.rsp1_valid, bus.rsp1_rdata};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.lock       = v.lk;
        bus.req0_valid = v.v0; bus.req0_we = v.we0; bus.req0_addr = v.a0; bus.req0_wdata = v.d0;
        bus.req1_valid = v.v1; bus.req1_we = v.we1; bus.req1_addr = v.a1; bus.req1_wdata = v.d1;
    endtask

    task automatic idle();
        bus.lock       = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    initial begin
        // Reset held with both ports requesting: nothing may be granted.
        reset = 1'b1;
        idle();
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0010;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 16'h0005;
        #2;
        check("reset_state", sample(), 70'd0);
        @(negedge clk);
        idle();
        reset = 1'b0;

        //  lk  v0 we0 a0     d0      v1 we1 a1     d1       r0 r1 en we addr   wd       s0v s0d     s1v s1d
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,0,16'h10,16'h0,    0,0,16'h00,16'h0,     1,0,1,0,16'h10,16'h0,     0,16'h0,    0,16'h0);
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     1,16'h1234, 0,16'h0);
        add(1, 1,0,16'h01,16'h0,    1,0,16'h10,16'h0,     1,0,1,0,16'h01,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,0,16'h01,16'h0,    1,0,16'h10,16'h0,     1,0,1,0,16'h01,16'h0,     1,16'hA1,   0,16'h0);
        add(1, 1,0,16'h01,16'h0,    1,0,16'h10,16'h0,     1,0,1,0,16'h01,16'h0,     1,16'hA1,   0,16'h0);
        add(1, 1,0,16'h01,16'h0,    1,0,16'h10,16'h0,     0,1,1,0,16'h10,16'h0,     1,16'hA1,   0,16'h0);
        add(1, 1,0,16'h01,16'h0,    1,0,16'h10,16'h0,     1,0,1,0,16'h01,16'h0,     0,16'h0,    1,16'h1234);
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     1,16'hA1,   0,16'h0);
        add(1, 0,0,16'h00,16'h0,    1,1,16'h05,16'hBEEF,  0,1,1,1,16'h05,16'hBEEF,  0,16'h0,    0,16'h0);
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,0,16'h02,16'h0,    1,0,16'h05,16'h0,     1,0,1,0,16'h02,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,0,16'h02,16'h0,    1,0,16'h05,16'h0,     1,0,1,0,16'h02,16'h0,     1,16'hA2,   0,16'h0);
        add(0, 1,0,16'h02,16'h0,    1,0,16'h05,16'h0,     0,0,0,0,16'h00,16'h0,     1,16'hA2,   0,16'h0);
        for (int i = 0; i < 4; i++)
            add(0, 1,0,16'h02,16'h0, 1,0,16'h05,16'h0,    0,0,0,0,16'h00,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,0,16'h02,16'h0,    1,0,16'h05,16'h0,     1,0,1,0,16'h02,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,0,16'h02,16'h0,    1,0,16'h05,16'h0,     0,1,1,0,16'h05,16'h0,     1,16'hA2,   0,16'h0);
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     0,16'h0,    1,16'hBEEF);
        add(1, 1,0,16'h01,16'h0,    0,0,16'h00,16'h0,     1,0,1,0,16'h01,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,0,16'h02,16'h0,    0,0,16'h00,16'h0,     1,0,1,0,16'h02,16'h0,     1,16'hA1,   0,16'h0);
        add(1, 1,0,16'h03,16'h0,    0,0,16'h00,16'h0,     1,0,1,0,16'h03,16'h0,     1,16'hA2,   0,16'h0);
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     1,16'hA3,   0,16'h0);
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     0,16'h0,    0,16'h0);
        add(1, 1,1,16'h20,16'h5555, 1,0,16'h20,16'h0,     1,0,1,1,16'h20,16'h5555,  0,16'h0,    0,16'h0);
        add(1, 0,0,16'h00,16'h0,    1,0,16'h20,16'h0,     0,1,1,0,16'h20,16'h0,     0,16'h0,    0,16'h0);
        add(1, 0,0,16'h00,16'h0,    0,0,16'h00,16'h0,     0,0,0,0,16'h00,16'h0,     0,16'h0,    1,16'h5555);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // Read accepted, then reset pulsed in the middle of the response cycle.
        @(negedge clk);
        idle();
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0003;
        #2;
        check("t5_accept", {66'd0, bus.req0_ready, bus.mem_en, bus.mem_we, bus.req1_ready}, {66'd0, 4'b1100});
        @(posedge clk);
        #2;
        check("t5_rsp_before_reset", {53'd0, bus.rsp0_valid, bus.rsp0_rdata}, {53'd0, 1'b1, 16'h00A3});
        #1 reset = 1'b1;
        #1;
        check("t5_rsp_dropped", sample(), 70'd0);
        @(negedge clk);
        @(negedge clk);
        idle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("t5_no_rsp%0d", i), {68'd0, bus.rsp0_valid, bus.rsp1_valid}, 70'd0);
            @(negedge clk);
        end
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0002;
        #2;
        check("t5_grant_resumes", {52'd0, bus.req0_ready, bus.req1_ready, bus.mem_addr},
              {52'd0, 1'b1, 1'b0, 16'h0001});
        @(negedge clk);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
